// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Optional feature macro MDU_FAST_EN: every mult/div op completes after a single busy cycle.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset; clears HI, LO, cnt and any pending result
//   HILOOp   0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mthi, 6 mflo, 7 mtlo, 8-15 none
//   A, B     rs / rt operands
//   start    high when a mult/div op is accepted this cycle
//   busy     high while an operation is in flight
//   HILO_out HI for mfhi, LO for mflo, otherwise 0
module md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  HILOOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HILO_out
);
`ifdef MDU_FAST_EN
  localparam logic [3:0] MUL_LAT = 4'd1;
  localparam logic [3:0] DIV_LAT = 4'd1;
`else
  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;
`endif
  logic [31:0] hi, lo, dvs;
  logic [3:0]  cnt;
  logic [63:0] pend, prod, quo_rem;
  logic        pend_wr;
  assign busy     = cnt != 4'd0;
  assign start    = HILOOp <= 4'd3 && !busy;
  assign HILO_out = HILOOp == 4'd4 ? hi : HILOOp == 4'd6 ? lo : 32'd0;
  // divisor forced nonzero so the divider never sees /0; the write is suppressed instead
  assign dvs = B == 32'd0 ? 32'd1 : B;
  always_comb begin
    prod    = HILOOp[0] ? {32'd0, A} * {32'd0, B}
                        : {{32{A[31]}}, A} * {{32{B[31]}}, B};
    quo_rem = HILOOp[0] ? {A % dvs, A / dvs}
                        : {32'($signed(A) % $signed(dvs)), 32'($signed(A) / $signed(dvs))};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      cnt     <= 4'd0;
      pend    <= 64'd0;
      pend_wr <= 1'b0;
    end else if (start) begin
      cnt     <= HILOOp[1] ? DIV_LAT : MUL_LAT;
      pend    <= HILOOp[1] ? quo_rem : prod;
      pend_wr <= !HILOOp[1] || B != 32'd0;
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && pend_wr) {hi, lo} <= pend;
    end else if (HILOOp == 4'd5) begin
      hi <= A;
    end else if (HILOOp == 4'd7) begin
      lo <= A;
    end
  end
endmodule
